// File: rtl/dvp_pkg.sv
// Shared types and helpers for the DVP capture front end.
// Capture FSM states, vsync polarity codes, crop compare.
package dvp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SKIP   = 2'd1,
    SYNC   = 2'd2,
    ACTIVE = 2'd3
  } dvp_state_e;

  localparam logic VS_ACT_HIGH = 1'b1;
  localparam logic VS_ACT_LOW  = 1'b0;

  // Wide enough for any CNT_W up to 32 plus a carry bit.
  localparam int WIN_W = 33;
  typedef logic [WIN_W-1:0] win_t;

  // lo <= v < lo+len, evaluated without wrap.
  function automatic logic in_win(
    input win_t v,
    input win_t lo,
    input win_t len
  );
    return (v >= lo) && (v < (lo + len));
  endfunction

endpackage

// File: rtl/dvp_beat_packer.sv
// Beat assembler: gathers BEATS sensor words into one pixel.
// Also flags lines whose length is not a whole pixel count.
module dvp_beat_packer
  import dvp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BEATS  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    href_i,
  input  logic [DATA_W-1:0]       din_i,
  input  logic                    swap_i,
  output logic                    done_o,
  output logic [DATA_W*BEATS-1:0] word_o,
  output logic                    fall_o,
  output logic                    err_o
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  logic [BW-1:0]           beat_q, beat_d;
  logic                    swap_q;
  logic                    swap_eff;
  logic [BW-1:0]           slot;
  logic [DATA_W*BEATS-1:0] acc_q;
  logic [DATA_W*BEATS-1:0] word;
  logic                    href_q;

  // Place the current beat into its slice on top of earlier beats.
  always_comb begin
    swap_eff = (beat_q == '0) ? swap_i : swap_q;
    slot     = swap_eff ? beat_q : (LAST - beat_q);
    word     = acc_q;
    for (int k = 0; k < BEATS; k++) begin
      if (int'(slot) == k) word[k*DATA_W +: DATA_W] = din_i;
    end
  end

  assign done_o = href_i && (beat_q == LAST);
  assign word_o = word;
  assign fall_o = href_q && !href_i;
  assign err_o  = fall_o && (beat_q != '0);

  // Beat index: runs while href is high, restarts per pixel.
  always_comb begin
    beat_d = beat_q + BW'(1);
    if (clr_i || !href_i || done_o) beat_d = '0;
  end

  // Beat, swap latch, partial pixel and href history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      swap_q <= 1'b0;
      acc_q  <= '0;
      href_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      href_q <= clr_i ? 1'b0 : href_i;
      if (href_i && !clr_i) acc_q <= word;
      if (href_i && (beat_q == '0)) swap_q <= swap_i;
    end
  end

endmodule

// File: rtl/dvp_capture_packer.sv
// DVP capture front end: input stage, capture FSM, counters,
// crop window and frame pulses around the beat packer.
module dvp_capture_packer
  import dvp_pkg::*;
#(
  parameter int   DATA_W      = 8,
  parameter int   BEATS       = 2,
  parameter int   CNT_W       = 12,
  parameter int   SKIP_FRAMES = 10,
  parameter logic VS_POL      = VS_ACT_HIGH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    swap_bytes,
  input  logic [CNT_W-1:0]        crop_x0,
  input  logic [CNT_W-1:0]        crop_y0,
  input  logic [CNT_W-1:0]        crop_w,
  input  logic [CNT_W-1:0]        crop_h,
  input  logic                    vsync,
  input  logic                    href,
  input  logic [DATA_W-1:0]       din,
  output logic                    pix_valid,
  output logic [DATA_W*BEATS-1:0] pix_data,
  output logic [CNT_W-1:0]        pix_x,
  output logic [CNT_W-1:0]        pix_y,
  output logic                    frame_start,
  output logic                    frame_end,
  output logic                    frame_active,
  output logic                    line_err,
  output logic [15:0]             frame_cnt
);

  localparam int SK_W =
    (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic VS_IDLE =
    (VS_POL == VS_ACT_HIGH) ? VS_ACT_LOW : VS_ACT_HIGH;

  logic                    vs_s1_q, href_s1_q;
  logic [DATA_W-1:0]       din_s1_q;
  logic                    vs_prev_q;
  logic                    vs_act, vs_rise, boundary;

  dvp_state_e              state_q, state_d;
  logic                    st_skip, st_armed, st_active;
  logic [SK_W-1:0]         skip_q;
  logic                    skip_last;

  logic [CNT_W-1:0]        x_q, y_q;
  logic [CNT_W-1:0]        cx0_q, cy0_q, cw_q, ch_q;

  logic                    pk_done, pk_fall, pk_err;
  logic [DATA_W*BEATS-1:0] pk_word;

  logic                    fs_hit, fe_hit, in_x, in_y, emit;

  logic                    pv_q, fs_q, fe_q, fa_q, le_q;
  logic [DATA_W*BEATS-1:0] pd_q;
  logic [CNT_W-1:0]        px_q, py_q;
  logic [15:0]             fcnt_q;

  // Single register stage on the raw sensor pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_s1_q   <= VS_IDLE;
      href_s1_q <= 1'b0;
      din_s1_q  <= '0;
      vs_prev_q <= 1'b0;
    end else begin
      vs_s1_q   <= vsync;
      href_s1_q <= href;
      din_s1_q  <= din;
      vs_prev_q <= vs_act;
    end
  end

  assign vs_act   = (vs_s1_q == VS_POL);
  assign vs_rise  = vs_act && !vs_prev_q;
  assign boundary = !vs_act && vs_prev_q;

  dvp_beat_packer #(
    .DATA_W (DATA_W),
    .BEATS  (BEATS)
  ) u_pack (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (boundary),
    .href_i (href_s1_q),
    .din_i  (din_s1_q),
    .swap_i (swap_bytes),
    .done_o (pk_done),
    .word_o (pk_word),
    .fall_o (pk_fall),
    .err_o  (pk_err)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign skip_last = (int'(skip_q) == SKIP_FRAMES - 1);

  // FSM next state; losing enable always returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (enable)
          state_d = (SKIP_FRAMES > 0) ? SKIP : SYNC;
      SKIP:
        if (vs_rise && skip_last) state_d = SYNC;
      SYNC:
        if (boundary) state_d = ACTIVE;
      ACTIVE:
        state_d = ACTIVE;
      default:
        state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // FSM output decode.
  always_comb begin
    st_skip   = 1'b0;
    st_armed  = 1'b0;
    st_active = 1'b0;
    unique case (state_q)
      SKIP:   st_skip = 1'b1;
      SYNC:   st_armed = 1'b1;
      ACTIVE: begin
        st_armed  = 1'b1;
        st_active = 1'b1;
      end
      default: ;
    endcase
  end

  // Count vsync assertions while discarding frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       skip_q <= '0;
    else if (!st_skip) skip_q <= '0;
    else if (vs_rise) skip_q <= skip_q + SK_W'(1);
  end

  // Raw column/line position; the frame boundary overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (boundary) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pk_fall) begin
      x_q <= '0;
      y_q <= y_q + CNT_W'(1);
    end else if (pk_done) begin
      x_q <= x_q + CNT_W'(1);
    end
  end

  assign fs_hit = enable && boundary && st_armed;
  assign fe_hit = enable && vs_rise && fa_q;

  // Crop settings are frozen for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx0_q <= '0;
      cy0_q <= '0;
      cw_q  <= '0;
      ch_q  <= '0;
    end else if (fs_hit) begin
      cx0_q <= crop_x0;
      cy0_q <= crop_y0;
      cw_q  <= crop_w;
      ch_q  <= crop_h;
    end
  end

  assign in_x = in_win(win_t'(x_q), win_t'(cx0_q), win_t'(cw_q));
  assign in_y = in_win(win_t'(y_q), win_t'(cy0_q), win_t'(ch_q));
  assign emit = enable && st_active && fa_q && pk_done
             && !boundary && in_x && in_y;

  // Registered pixel, frame and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q   <= 1'b0;
      pd_q   <= '0;
      px_q   <= '0;
      py_q   <= '0;
      fs_q   <= 1'b0;
      fe_q   <= 1'b0;
      fa_q   <= 1'b0;
      le_q   <= 1'b0;
      fcnt_q <= '0;
    end else begin
      pv_q <= emit;
      fs_q <= fs_hit;
      fe_q <= fe_hit;
      le_q <= enable && fa_q && pk_err;
      if (emit) begin
        pd_q <= pk_word;
        px_q <= x_q - cx0_q;
        py_q <= y_q - cy0_q;
      end
      if (fe_hit) fcnt_q <= fcnt_q + 16'd1;
      if (!enable)     fa_q <= 1'b0;
      else if (fs_hit) fa_q <= 1'b1;
      else if (fe_hit) fa_q <= 1'b0;
    end
  end

  assign pix_valid    = pv_q;
  assign pix_data     = pd_q;
  assign pix_x        = px_q;
  assign pix_y        = py_q;
  assign frame_start  = fs_q;
  assign frame_end    = fe_q;
  assign frame_active = fa_q;
  assign line_err     = le_q;
  assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_dvp_capture_packer.sv
// Directed bench for dvp_capture_packer: packing, swap, skip,
// crop, malformed lines, enable drop and async reset.
module tb_dvp_capture_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        swap_bytes = 1'b0;
  logic [11:0] crop_x0 = '0;
  logic [11:0] crop_y0 = '0;
  logic [11:0] crop_w = 12'hFFF;
  logic [11:0] crop_h = 12'hFFF;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  din = '0;

  logic        d_pv, d_fs, d_fe, d_fa, d_le;
  logic [15:0] d_pd, d_fcnt;
  logic [11:0] d_px, d_py;
  logic        s_pv, s_fs, s_fe, s_fa, s_le;
  logic [15:0] s_pd, s_fcnt;
  logic [11:0] s_px, s_py;

  always #5 clk = ~clk;

  dvp_capture_packer #(
    .DATA_W(8), .BEATS(2), .CNT_W(12),
    .SKIP_FRAMES(0), .VS_POL(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .swap_bytes(swap_bytes),
    .crop_x0(crop_x0), .crop_y0(crop_y0),
    .crop_w(crop_w), .crop_h(crop_h),
    .vsync(vsync), .href(href), .din(din),
    .pix_valid(d_pv), .pix_data(d_pd),
    .pix_x(d_px), .pix_y(d_py),
    .frame_start(d_fs), .frame_end(d_fe),
    .frame_active(d_fa), .line_err(d_le),
    .frame_cnt(d_fcnt)
  );

  dvp_capture_packer #(
    .DATA_W(8), .BEATS(2), .CNT_W(12),
    .SKIP_FRAMES(2), .VS_POL(1'b1)
  ) u_skp (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .swap_bytes(swap_bytes),
    .crop_x0(crop_x0), .crop_y0(crop_y0),
    .crop_w(crop_w), .crop_h(crop_h),
    .vsync(vsync), .href(href), .din(din),
    .pix_valid(s_pv), .pix_data(s_pd),
    .pix_x(s_px), .pix_y(s_py),
    .frame_start(s_fs), .frame_end(s_fe),
    .frame_active(s_fa), .line_err(s_le),
    .frame_cnt(s_fcnt)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int cyc22 = -1;
  int first_pv = -1;
  int n_fs = 0, n_fe = 0, n_le = 0;
  int sn_fs = 0, sn_fe = 0, sn_pv = 0;
  logic [15:0] qd[$];
  logic [11:0] qx[$];
  logic [11:0] qy[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (d_pv) begin
      qd.push_back(d_pd);
      qx.push_back(d_px);
      qy.push_back(d_py);
      if (first_pv < 0) first_pv = cyc;
    end
    if (d_fs) n_fs++;
    if (d_fe) n_fe++;
    if (d_le) n_le++;
    if (s_fs) sn_fs++;
    if (s_fe) sn_fe++;
    if (s_pv) sn_pv++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic step(input logic vs, input logic hr,
                      input logic [7:0] d);
    vsync = vs;
    href  = hr;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vpulse();
    repeat (4) step(1'b1, 1'b0, 8'h00);
    idle(4);
  endtask

  task automatic line_seq();
    for (int k = 0; k < 8; k++) begin
      if (k == 1 && cyc22 < 0) cyc22 = cyc;
      step(1'b0, 1'b1, 8'((k + 1) * 17));
    end
    idle(4);
  endtask

  task automatic line_xy(input int npix, input int y);
    for (int x = 0; x < npix; x++) begin
      step(1'b0, 1'b1, 8'(x));
      step(1'b0, 1'b1, 8'(y));
    end
  endtask

  int b;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_pv", 32'(d_pv), 32'd0);
    check("rst_pd", 32'(d_pd), 32'd0);
    check("rst_fa", 32'(d_fa), 32'd0);
    check("rst_fcnt", 32'(d_fcnt), 32'd0);
    check("rst_skp_fa", 32'(s_fa), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Enable arrives while vsync is already asserted.
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    enable = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    idle(4);

    // F1: 4x2, swap off.
    line_seq();
    line_seq();
    check("f1_n", qd.size(), 8);
    check("f1_first", 32'(qd[0]), 32'h1122);
    check("f1_last", 32'(qd[7]), 32'h7788);
    check("f1_lastxy", 32'({qx[7], qy[7]}), 32'h003001);
    check("f1_lat", first_pv - cyc22, 2);
    check("f1_fs", n_fs, 1);
    check("f1_fa", 32'(d_fa), 32'd1);
    check("f1_cnt0", 32'(d_fcnt), 32'd0);
    swap_bytes = 1'b1;
    vpulse();
    check("f1_fe", n_fe, 1);
    check("f1_cnt1", 32'(d_fcnt), 32'd1);

    // F2: same bytes, swapped.
    b = qd.size();
    line_seq();
    line_seq();
    check("f2_n", qd.size() - b, 8);
    check("f2_first", 32'(qd[b]), 32'h2211);
    check("f2_last", 32'(qd[b+7]), 32'h8877);
    check("skp_fs0", sn_fs, 0);
    check("skp_pv0", sn_pv, 0);
    swap_bytes = 1'b0;
    crop_x0 = 12'd4;
    crop_y0 = 12'd2;
    crop_w  = 12'd8;
    crop_h  = 12'd3;
    vpulse();
    check("f2_cnt", 32'(d_fcnt), 32'd2);
    check("skp_fs1", sn_fs, 1);

    // F3: 16x8 with crop window.
    b = qd.size();
    for (int y = 0; y < 8; y++) begin
      line_xy(16, y);
      idle(4);
    end
    check("f3_n", qd.size() - b, 24);
    check("f3_first", 32'(qd[b]), 32'h0402);
    check("f3_fxy", 32'({qx[b], qy[b]}), 32'h0);
    check("f3_last", 32'(qd[b+23]), 32'h0B04);
    check("f3_lxy", 32'({qx[b+23], qy[b+23]}), 32'h007002);
    check("skp_pv24", sn_pv, 24);
    crop_x0 = 12'd0;
    crop_y0 = 12'd0;
    crop_w  = 12'hFFF;
    crop_h  = 12'hFFF;
    vpulse();
    check("f3_cnt", 32'(d_fcnt), 32'd3);
    check("skp_fe", sn_fe, 1);
    check("skp_cnt", 32'(s_fcnt), 32'd1);

    // F4: 7-byte line, then a good line.
    b = qd.size();
    line_xy(3, 0);
    step(1'b0, 1'b1, 8'hEE);
    idle(4);
    check("f4_le", n_le, 1);
    check("f4_n3", qd.size() - b, 3);
    line_xy(2, 1);
    idle(4);
    check("f4_n5", qd.size() - b, 5);
    check("f4_x0", 32'(qd[b+3]), 32'h0001);
    check("f4_x0xy", 32'({qx[b+3], qy[b+3]}), 32'h000001);
    check("f4_le1", n_le, 1);

    // Enable dropped mid-line.
    line_xy(2, 2);
    enable = 1'b0;
    step(1'b0, 1'b1, 8'h02);
    check("drop_pv", 32'(d_pv), 32'd0);
    check("drop_fa", 32'(d_fa), 32'd0);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h03);
    step(1'b0, 1'b1, 8'h02);
    idle(4);
    vpulse();
    check("drop_n", qd.size() - b, 6);
    check("drop_fe", n_fe, 3);
    check("drop_cnt", 32'(d_fcnt), 32'd3);

    // F5: re-enable, then async reset mid-line.
    enable = 1'b1;
    idle(2);
    vpulse();
    line_xy(2, 0);
    idle(3);
    check("f5_fa", 32'(d_fa), 32'd1);
    check("f5_pd", 32'(d_pd), 32'h0100);
    step(1'b0, 1'b1, 8'h05);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pv", 32'(d_pv), 32'd0);
    check("arst_pd", 32'(d_pd), 32'd0);
    check("arst_fa", 32'(d_fa), 32'd0);
    check("arst_cnt", 32'(d_fcnt), 32'd0);
    check("arst_px", 32'(d_px), 32'd0);
    check("arst_skp", 32'(s_fcnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
